// File: rtl/rv_dm_bridge_pkg.sv
// Shared definitions for the core data-memory to Wishbone bridge:
// FSM state encoding, timeout counter width and default timeout.
package rv_dm_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int          CNT_W           = 10;

endpackage

// File: rtl/rv_dm_bridge.sv
// Single-outstanding bridge from the core data-memory port to a pipelined
// Wishbone B4 master, with bus-error and timeout reporting.
module rv_dm_bridge
    import rv_dm_bridge_pkg::*;
#(
    parameter int unsigned g_timeout = DEFAULT_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_error_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(g_timeout - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      adr_q, adr_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;
    logic             we_q, we_d;
    logic [31:0]      data_l_q, data_l_d;
    logic             load_done_q, load_done_d;
    logic             store_done_q, store_done_d;
    logic             error_q, error_d;

    logic accept;
    logic resp;
    logic expired;
    logic finish;
    logic failed;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        we_d         = we_q;
        data_l_d     = data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        error_d      = 1'b0;
        finish       = 1'b0;
        failed       = 1'b0;

        accept  = (state_q == ST_IDLE) && (dm_load_i || dm_store_i);
        // A response only counts once the slave has taken the strobe.
        resp    = (wb_ack_i || wb_err_i) &&
                  ((state_q == ST_WAIT) || ((state_q == ST_ISSUE) && !wb_stall_i));
        expired = (cnt_q == LIMIT);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    adr_d   = {dm_addr_i[31:2], dm_addr_i[1:0] & 2'b00};
                    sel_d   = dm_store_i ? dm_data_select_i : 4'hF;
                    dat_d   = dm_data_s_i;
                    we_d    = dm_store_i;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (resp || expired) begin
                    // A real response in the last allowed cycle beats the timeout.
                    finish  = 1'b1;
                    failed  = resp ? wb_err_i : 1'b1;
                    state_d = ST_IDLE;
                end else if ((state_q == ST_ISSUE) && !wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            load_done_d  = !we_q;
            store_done_d = we_q;
            error_d      = failed;
            if (!we_q) begin
                data_l_d = failed ? 32'h0 : wb_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            data_l_q     <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            error_q      <= error_d;
        end
    end

    // Reset abandons the bus cycle immediately, not one clock later.
    assign dm_ready_o      = (state_q == ST_IDLE) && !rst_i;
    assign wb_cyc_o        = (state_q != ST_IDLE) && !rst_i;
    assign wb_stb_o        = (state_q == ST_ISSUE) && !rst_i;
    assign wb_we_o         = we_q;
    assign wb_adr_o        = adr_q;
    assign wb_sel_o        = sel_q;
    assign wb_dat_o        = dat_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_error_o      = error_q;

endmodule

// File: tb/tb_rv_dm_bridge.sv
// Self-checking bench for rv_dm_bridge: directed vector table, randomized
// transactions against a transaction-level model, and a mid-flight reset.
module tb_rv_dm_bridge;

    localparam int TO = 8;

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stalls;
        int          delay;
        logic [1:0]  kind;
        logic [31:0] rdata;
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic        exp_we;
        int          exp_cyc;
        int          exp_stb;
        logic        exp_err;
        logic [31:0] exp_ldata;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] dm_addr_i, dm_data_s_i, wb_dat_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i, dm_store_i, wb_ack_i, wb_err_i, wb_stall_i;
    logic        dm_ready_o, dm_load_done_o, dm_store_done_o, dm_error_o;
    logic [31:0] dm_data_l_o, wb_adr_o, wb_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;

    int checks = 0;
    int errors = 0;

    rv_dm_bridge #(.g_timeout(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
        .dm_data_select_i(dm_data_select_i), .dm_load_i(dm_load_i),
        .dm_store_i(dm_store_i), .dm_ready_o(dm_ready_o),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .dm_error_o(dm_error_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel,
                                input int stalls, input int delay, input logic [1:0] kind,
                                input logic [31:0] rdata, input logic [31:0] exp_adr,
                                input logic [3:0] exp_sel, input logic exp_we,
                                input int exp_cyc, input int exp_stb, input logic exp_err,
                                input logic [31:0] exp_ldata);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.stalls = stalls; v.delay = delay; v.kind = kind; v.rdata = rdata;
        v.exp_adr = exp_adr; v.exp_sel = exp_sel; v.exp_we = exp_we;
        v.exp_cyc = exp_cyc; v.exp_stb = exp_stb; v.exp_err = exp_err;
        v.exp_ldata = exp_ldata;
        return v;
    endfunction

    // Transaction-level view: the slave answers in bus cycle stalls+1+delay
    // (counting from the first cyc cycle); anything beyond TO cycles is a timeout.
    function automatic vec_t ref_txn(input vec_t v, input logic [31:0] prev_ldata);
        vec_t r = v;
        int   resp_at = v.stalls + 1 + v.delay;
        bit   answered = (v.kind != 2'd0) && (resp_at <= TO);
        r.exp_adr = v.addr & 32'hFFFF_FFFC;
        r.exp_we  = v.st;
        r.exp_sel = v.st ? v.sel : 4'hF;
        r.exp_cyc = answered ? resp_at : TO;
        r.exp_stb = (v.stalls + 1 < r.exp_cyc) ? v.stalls + 1 : r.exp_cyc;
        r.exp_err = !(answered && v.kind == 2'd1);
        r.exp_ldata = v.st ? prev_ldata : (r.exp_err ? 32'h0 : v.rdata);
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int  cyc_n = 0;
        int  stb_n = 0;
        bit  done = 0;
        bit  resp;
        chk({tag, " ready_before"}, dm_ready_o, 1'b1);
        dm_load_i = v.ld; dm_store_i = v.st; dm_addr_i = v.addr;
        dm_data_s_i = v.wdata; dm_data_select_i = v.sel;
        tick();
        dm_load_i = 0; dm_store_i = 0; dm_addr_i = $urandom; dm_data_s_i = $urandom;
        dm_data_select_i = 4'($urandom);
        chk({tag, " adr"}, wb_adr_o, v.exp_adr);
        chk({tag, " sel"}, wb_sel_o, v.exp_sel);
        chk({tag, " we"}, wb_we_o, v.exp_we);
        chk({tag, " dat"}, wb_dat_o, v.wdata);
        chk({tag, " ready_busy"}, dm_ready_o, 1'b0);
        for (int i = 1; i <= TO + 3 && !done; i++) begin
            resp       = (v.kind != 2'd0) && (i == v.stalls + 1 + v.delay);
            wb_stall_i = (i <= v.stalls);
            wb_ack_i   = resp && v.kind[0];
            wb_err_i   = resp && v.kind[1];
            wb_dat_i   = resp ? v.rdata : $urandom;
            #1;
            if (wb_cyc_o) begin
                cyc_n++;
                if (wb_stb_o) stb_n++;
                tick();
            end else begin
                done = 1;
            end
        end
        chk({tag, " completed"}, done, 1'b1);
        chk({tag, " cyc_cycles"}, cyc_n, v.exp_cyc);
        chk({tag, " stb_cycles"}, stb_n, v.exp_stb);
        chk({tag, " load_done"}, dm_load_done_o, !v.st);
        chk({tag, " store_done"}, dm_store_done_o, v.st);
        chk({tag, " error"}, dm_error_o, v.exp_err);
        chk({tag, " ldata"}, dm_data_l_o, v.exp_ldata);
        chk({tag, " ready_done"}, dm_ready_o, 1'b1);
        wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0;
        tick();
        chk({tag, " pulses_clear"}, {dm_load_done_o, dm_store_done_o, dm_error_o}, 3'b000);
        chk({tag, " ldata_hold"}, dm_data_l_o, v.exp_ldata);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        logic [31:0] prev;
        int   k;

        tbl[0] = mk(1,0,32'h0000_1006,32'h0,4'h0, 0,2,2'd1,32'hCAFE_BABE, 32'h0000_1004,4'hF,0,3,1,0,32'hCAFE_BABE);
        tbl[1] = mk(0,1,32'h0000_0013,32'h5A5A_5A5A,4'b1000, 3,1,2'd1,32'h0, 32'h0000_0010,4'b1000,1,5,4,0,32'hCAFE_BABE);
        tbl[2] = mk(1,0,32'h0000_2000,32'h0,4'h0, 0,0,2'd0,32'h0, 32'h0000_2000,4'hF,0,8,1,1,32'h0);
        tbl[3] = mk(0,1,32'h0000_0044,32'h1234_5678,4'b0011, 1,1,2'd2,32'h0, 32'h0000_0044,4'b0011,1,3,2,1,32'h0);
        tbl[4] = mk(1,1,32'h0000_0105,32'hDEAD_BEEF,4'b0101, 0,0,2'd1,32'h0, 32'h0000_0104,4'b0101,1,1,1,0,32'h0);
        tbl[5] = mk(1,0,32'h0000_0030,32'h0,4'h0, 0,1,2'd1,32'h1111_2222, 32'h0000_0030,4'hF,0,2,1,0,32'h1111_2222);
        tbl[6] = mk(1,0,32'h0000_0008,32'h0,4'h0, 0,1,2'd3,32'h1234_0000, 32'h0000_0008,4'hF,0,2,1,1,32'h0);
        tbl[7] = mk(1,0,32'h0000_0F0F,32'h0,4'h0, 10,0,2'd1,32'h5555_5555, 32'h0000_0F0C,4'hF,0,8,8,1,32'h0);
        tbl[8] = mk(1,0,32'h0000_0F00,32'h0,4'h0, 0,7,2'd1,32'hA5A5_0F0F, 32'h0000_0F00,4'hF,0,8,1,0,32'hA5A5_0F0F);

        rst_i = 1; dm_load_i = 0; dm_store_i = 0; dm_addr_i = 0; dm_data_s_i = 0;
        dm_data_select_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0;
        tick();
        tick();
        chk("rst ready", dm_ready_o, 1'b0);
        chk("rst cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        chk("rst adr", wb_adr_o, 32'h0);
        chk("rst sel", wb_sel_o, 4'h0);
        chk("rst dat", wb_dat_o, 32'h0);
        chk("rst ldata", dm_data_l_o, 32'h0);
        chk("rst pulses", {dm_load_done_o, dm_store_done_o, dm_error_o}, 3'b000);
        rst_i = 0;
        #1;
        chk("post_rst ready", dm_ready_o, 1'b1);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Late ack after a timeout must be ignored in IDLE.
        v = mk(1,0,32'h0000_0200,32'h0,4'h0, 0,8,2'd1,32'h7777_7777, 32'h0000_0200,4'hF,0,8,1,1,32'h0);
        run_txn(v, "late_ack");

        prev = 32'h0;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(1, 3);
            v.ld = k[0]; v.st = k[1];
            v.addr = $urandom; v.wdata = $urandom; v.sel = 4'($urandom);
            v.stalls = $urandom_range(0, 3);
            v.delay  = $urandom_range(0, 7);
            k = $urandom_range(0, 5);
            v.kind = (k == 0) ? 2'd0 : (k <= 3) ? 2'd1 : (k == 4) ? 2'd2 : 2'd3;
            v.rdata = $urandom;
            v = ref_txn(v, prev);
            run_txn(v, $sformatf("rnd%0d", n));
            prev = v.exp_ldata;
        end

        // Reset during WAIT of a load, with a request presented while reset is high.
        chk("mid_rst ready_before", dm_ready_o, 1'b1);
        dm_load_i = 1; dm_addr_i = 32'h0000_0400;
        tick();
        dm_load_i = 0;
        tick();
        chk("mid_rst in_wait", {wb_cyc_o, wb_stb_o}, 2'b10);
        rst_i = 1; dm_store_i = 1;
        #1;
        chk("mid_rst cyc_drop", {wb_cyc_o, wb_stb_o}, 2'b00);
        chk("mid_rst ready_low", dm_ready_o, 1'b0);
        tick();
        rst_i = 0; dm_store_i = 0; wb_ack_i = 1; wb_dat_i = 32'hBAD0_BAD0;
        #1;
        chk("mid_rst no_accept", wb_cyc_o, 1'b0);
        chk("mid_rst no_pulse", {dm_load_done_o, dm_store_done_o, dm_error_o}, 3'b000);
        chk("mid_rst ready_back", dm_ready_o, 1'b1);
        tick();
        wb_ack_i = 0;
        chk("mid_rst late_ack_ignored", {dm_load_done_o, dm_store_done_o, dm_error_o, wb_cyc_o}, 4'b0000);
        chk("mid_rst ldata", dm_data_l_o, 32'h0);
        v = mk(1,0,32'h0000_0402,32'h0,4'h0, 1,1,2'd1,32'h0BAD_F00D, 32'h0000_0400,4'hF,0,3,2,0,32'h0BAD_F00D);
        run_txn(v, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
